// File: rtl/qnigma_mod_addsub_seq.sv
// Limb-serial modular add/subtract sequencer with a private operand register file.
// Adds constant-time equality compare, copy and conditional swap; latency is data-independent.
module qnigma_mod_addsub_seq #(
   parameter int FW = 255,
   parameter int LW = 32,
   parameter int NREG = 16,
   parameter logic [FW-1:0] P = {FW{1'b1}} - FW'(18),
   localparam int NL = (FW + LW - 1) / LW,
   localparam int PW = NL * LW,
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1,
   localparam int LA = (NL > 1) ? $clog2(NL) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          task_val,
   output logic          task_rdy,
   input  logic [2:0]    task_op,
   input  logic [AW-1:0] task_a,
   input  logic [AW-1:0] task_b,
   input  logic [AW-1:0] task_d,
   input  logic          task_cnd,
   output logic          task_done,
   output logic          eql,
   input  logic          ext_wr_val,
   input  logic [AW-1:0] ext_wr_ptr,
   input  logic [LA-1:0] ext_wr_lmb,
   input  logic [LW-1:0] ext_wr_dat,
   input  logic [AW-1:0] ext_rd_ptr,
   input  logic [LA-1:0] ext_rd_lmb,
   output logic [LW-1:0] ext_rd_dat
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMMIT} state_t;
   typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SUB = 3'd1, OP_CPY = 3'd2,
                             OP_EQL = 3'd3, OP_CSW = 3'd4} op_t;

   localparam logic [PW-1:0] P_PAD = PW'(P);

   state_t        state, state_nxt;
   logic [2:0]    op_q;
   logic [AW-1:0] a_q, b_q, d_q;
   logic          cnd_q;
   logic [PW-1:0] sa, sb, r0, r1;
   logic          f0, f1, diff;
   logic [LA-1:0] cnt;
   logic [PW-1:0] rf [NREG];

   logic [PW-1:0] rf_a, rf_b;
   logic [LW-1:0] sa_l, sb_l, p_l;
   logic [LW:0]   x0, x1;
   logic          cw0, cw1, xw;
   logic [AW-1:0] ci0, ci1;
   logic [PW-1:0] cv0, cv1;

   assign task_rdy  = (state == S_IDLE);
   assign task_done = (state == S_COMMIT);
   assign xw        = ext_wr_val && (int'(ext_wr_lmb) < NL);

   always_comb begin
      rf_a = '0;
      rf_b = '0;
      if (int'(task_a) < NREG) rf_a = rf[task_a];
      if (int'(task_b) < NREG) rf_b = rf[task_b];
   end

   // x0 is the primary limb (ADD sum / SUB difference), x1 the P-adjusted limb.
   // Bit LW of each carries the carry/borrow into the next limb.
   always_comb begin
      sa_l = sa[LW-1:0];
      sb_l = sb[LW-1:0];
      p_l  = P_PAD[int'(cnt) * LW +: LW];
      if (op_q == OP_SUB) begin
         x0 = {1'b0, sa_l} - {1'b0, sb_l} - {{LW{1'b0}}, f0};
         x1 = {1'b0, x0[LW-1:0]} + {1'b0, p_l} + {{LW{1'b0}}, f1};
      end else begin
         x0 = {1'b0, sa_l} + {1'b0, sb_l} + {{LW{1'b0}}, f0};
         x1 = {1'b0, x0[LW-1:0]} - {1'b0, p_l} - {{LW{1'b0}}, f1};
      end
   end

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (task_val)
               state_nxt = (task_op == OP_ADD || task_op == OP_SUB || task_op == OP_EQL)
                           ? S_RUN : S_COMMIT;
         S_RUN:    if (cnt == LA'(NL - 1)) state_nxt = S_COMMIT;
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Register-file write ports active in COMMIT; CSW uses both, every other op only port 0.
   always_comb begin
      cw0 = 1'b0;
      cw1 = 1'b0;
      ci0 = d_q;
      ci1 = b_q;
      cv0 = r0;
      cv1 = sa;
      if (state == S_COMMIT) begin
         case (op_q)
            OP_ADD: begin cw0 = 1'b1; cv0 = (f0 | ~f1) ? r1 : r0; end
            OP_SUB: begin cw0 = 1'b1; cv0 = f0 ? r1 : r0; end
            OP_CPY: begin cw0 = 1'b1; cv0 = sa; end
            OP_CSW:
               if (cnd_q) begin
                  cw0 = 1'b1;
                  ci0 = a_q;
                  cv0 = sb;
                  cw1 = 1'b1;
               end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         d_q   <= '0;
         cnd_q <= 1'b0;
         sa    <= '0;
         sb    <= '0;
         r0    <= '0;
         r1    <= '0;
         f0    <= 1'b0;
         f1    <= 1'b0;
         diff  <= 1'b0;
         cnt   <= '0;
         eql   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && task_val) begin
            op_q  <= task_op;
            a_q   <= task_a;
            b_q   <= task_b;
            d_q   <= task_d;
            cnd_q <= task_cnd;
            sa    <= rf_a;
            sb    <= rf_b;
            r0    <= '0;
            r1    <= '0;
            f0    <= 1'b0;
            f1    <= 1'b0;
            diff  <= 1'b0;
            cnt   <= '0;
         end else if (state == S_RUN) begin
            sa   <= sa >> LW;
            sb   <= sb >> LW;
            r0   <= (r0 >> LW) | (PW'(x0[LW-1:0]) << (PW - LW));
            r1   <= (r1 >> LW) | (PW'(x1[LW-1:0]) << (PW - LW));
            f0   <= x0[LW];
            f1   <= x1[LW];
            diff <= diff | (|(sa_l ^ sb_l));
            cnt  <= cnt + 1'b1;
         end
         if (state == S_COMMIT && op_q == OP_EQL) eql <= ~diff;
      end
   end

   // NOTE: the register file must come up all-zero, so it is built from resettable flops, not RAM.
   // A COMMIT write to a register overrides an external limb write to it in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (cw0 && ci0 == AW'(i))
               rf[i] <= cv0;
            else if (cw1 && ci1 == AW'(i))
               rf[i] <= cv1;
            else if (xw && ext_wr_ptr == AW'(i))
               rf[i][int'(ext_wr_lmb) * LW +: LW] <= ext_wr_dat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_rd_dat <= '0;
      end else begin
         ext_rd_dat <= '0;
         if (int'(ext_rd_ptr) < NREG && int'(ext_rd_lmb) < NL)
            ext_rd_dat <= rf[ext_rd_ptr][int'(ext_rd_lmb) * LW +: LW];
      end
   end

endmodule

// File: tb/tb_qnigma_mod_addsub_seq.sv
// Scoreboard bench for qnigma_mod_addsub_seq: default 255-bit field instance plus a
// 130-bit / 16-bit-limb instance for the narrow-limb and mid-task reset cases.
`timescale 1ns/1ps
module tb_qnigma_mod_addsub_seq;

   localparam int LW  = 32;
   localparam int NL  = 8;
   localparam int PW  = 256;
   localparam int LW2 = 16;
   localparam int NL2 = 9;
   localparam int PW2 = 144;
   localparam logic [PW-1:0] P1  = {1'b0, {255{1'b1}}} - 256'd18;
   localparam logic [129:0]  P2  = {130{1'b1}} - 130'd4;
   localparam logic [PW2-1:0] P2W = {14'd0, P2};

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, CPY = 3'd2, EQL = 3'd3, CSW = 3'd4, NOP = 3'd5;

   typedef struct packed {
      logic [3:0]    idx;
      logic [PW-1:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done2_cnt = 0;

   logic clk = 1'b0;
   logic rst_n, rst2_n;

   logic          task_val, task_cnd, task_rdy, task_done, eql;
   logic [2:0]    task_op;
   logic [3:0]    task_a, task_b, task_d;
   logic          ext_wr_val;
   logic [3:0]    ext_wr_ptr, ext_rd_ptr;
   logic [2:0]    ext_wr_lmb, ext_rd_lmb;
   logic [31:0]   ext_wr_dat, ext_rd_dat;

   logic          task_val2, task_cnd2, task_rdy2, task_done2, eql2;
   logic [2:0]    task_op2;
   logic [3:0]    task_a2, task_b2, task_d2;
   logic          ext_wr_val2;
   logic [3:0]    ext_wr_ptr2, ext_rd_ptr2;
   logic [3:0]    ext_wr_lmb2, ext_rd_lmb2;
   logic [15:0]   ext_wr_dat2, ext_rd_dat2;

   qnigma_mod_addsub_seq dut (
      .clk(clk), .rst_n(rst_n),
      .task_val(task_val), .task_rdy(task_rdy), .task_op(task_op),
      .task_a(task_a), .task_b(task_b), .task_d(task_d), .task_cnd(task_cnd),
      .task_done(task_done), .eql(eql),
      .ext_wr_val(ext_wr_val), .ext_wr_ptr(ext_wr_ptr), .ext_wr_lmb(ext_wr_lmb),
      .ext_wr_dat(ext_wr_dat), .ext_rd_ptr(ext_rd_ptr), .ext_rd_lmb(ext_rd_lmb),
      .ext_rd_dat(ext_rd_dat)
   );

   qnigma_mod_addsub_seq #(.FW(130), .LW(16), .NREG(16), .P(P2)) dut2 (
      .clk(clk), .rst_n(rst2_n),
      .task_val(task_val2), .task_rdy(task_rdy2), .task_op(task_op2),
      .task_a(task_a2), .task_b(task_b2), .task_d(task_d2), .task_cnd(task_cnd2),
      .task_done(task_done2), .eql(eql2),
      .ext_wr_val(ext_wr_val2), .ext_wr_ptr(ext_wr_ptr2), .ext_wr_lmb(ext_wr_lmb2),
      .ext_wr_dat(ext_wr_dat2), .ext_rd_ptr(ext_rd_ptr2), .ext_rd_lmb(ext_rd_lmb2),
      .ext_rd_dat(ext_rd_dat2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (task_done)  done_cnt++;
      if (task_done2) done2_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [3:0] i, input logic [PW-1:0] v);
      exp_t e;
      e.idx = i;
      e.val = v;
      return e;
   endfunction

   task automatic wr(input logic [3:0] r, input logic [PW-1:0] v);
      for (int l = 0; l < NL; l++) begin
         ext_wr_val = 1'b1;
         ext_wr_ptr = r;
         ext_wr_lmb = 3'(l);
         ext_wr_dat = v[l*LW +: LW];
         @(posedge clk); #1;
      end
      ext_wr_val = 1'b0;
   endtask

   task automatic rd(input logic [3:0] r, output logic [PW-1:0] v);
      v = '0;
      for (int l = 0; l < NL; l++) begin
         ext_rd_ptr = r;
         ext_rd_lmb = 3'(l);
         @(posedge clk); #1;
         v[l*LW +: LW] = ext_rd_dat;
      end
   endtask

   task automatic wr2(input logic [3:0] r, input logic [PW2-1:0] v);
      for (int l = 0; l < NL2; l++) begin
         ext_wr_val2 = 1'b1;
         ext_wr_ptr2 = r;
         ext_wr_lmb2 = 4'(l);
         ext_wr_dat2 = v[l*LW2 +: LW2];
         @(posedge clk); #1;
      end
      ext_wr_val2 = 1'b0;
   endtask

   task automatic rd2(input logic [3:0] r, output logic [PW2-1:0] v);
      v = '0;
      for (int l = 0; l < NL2; l++) begin
         ext_rd_ptr2 = r;
         ext_rd_lmb2 = 4'(l);
         @(posedge clk); #1;
         v[l*LW2 +: LW2] = ext_rd_dat2;
      end
   endtask

   // Issues one task on dut; lat is the cycle offset of task_done from the accept cycle,
   // acc the cycle stamp just after the accept edge. hold keeps task_val high until done.
   task automatic go(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] d, input logic cnd, input bit hold,
                     output int lat, output int acc);
      int n;
      n = 0;
      while (!task_rdy && n < 50) begin @(posedge clk); #1; n++; end
      task_op = op; task_a = a; task_b = b; task_d = d; task_cnd = cnd;
      task_val = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      if (!hold) task_val = 1'b0;
      n = 1;
      while (!task_done && n < 50) begin @(posedge clk); #1; n++; end
      lat = n;
      task_val = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      exp_t e;
      logic [PW-1:0] got;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         rd(e.idx, got);
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL %s r%0d got %h exp %h", name, e.idx, got, e.val);
         end
      end
   endtask

   task automatic test_reset();
      logic [PW-1:0] got;
      checks++;
      if (task_rdy !== 1'b1 || task_done !== 1'b0 || eql !== 1'b0 || ext_rd_dat !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs rdy=%b done=%b eql=%b rd=%h exp 1 0 0 0",
                  task_rdy, task_done, eql, ext_rd_dat);
      end
      rd(4'd5, got);
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL reset_reg got %h exp 0", got);
      end
   endtask

   task automatic test_add();
      int lat, acc;
      wr(4'd1, P1 - 256'd1);
      wr(4'd2, 256'd2);
      sb_q.push_back(mk(4'd1, 256'd1));
      go(ADD, 4'd1, 4'd2, 4'd1, 1'b0, 1'b0, lat, acc);
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL add_latency got %0d exp 9", lat); end
      wr(4'd3, 256'd5);
      wr(4'd4, 256'd7);
      sb_q.push_back(mk(4'd5, 256'd12));
      go(ADD, 4'd3, 4'd4, 4'd5, 1'b0, 1'b0, lat, acc);
      drain("add");
   endtask

   task automatic test_sub();
      int lat, acc;
      wr(4'd1, 256'd3);
      wr(4'd2, 256'd5);
      sb_q.push_back(mk(4'd6, P1 - 256'd2));
      go(SUB, 4'd1, 4'd2, 4'd6, 1'b0, 1'b0, lat, acc);
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL sub_latency got %0d exp 9", lat); end
      wr(4'd3, 256'd5);
      wr(4'd4, 256'd3);
      sb_q.push_back(mk(4'd7, 256'd2));
      go(SUB, 4'd3, 4'd4, 4'd7, 1'b0, 1'b0, lat, acc);
      wr(4'd8, 256'd99);
      sb_q.push_back(mk(4'd8, 256'd0));
      go(SUB, 4'd3, 4'd3, 4'd8, 1'b0, 1'b0, lat, acc);
      drain("sub");
   endtask

   task automatic test_alias();
      int lat, acc;
      wr(4'd9, (P1 + 256'd1) >> 1);
      sb_q.push_back(mk(4'd9, 256'd1));
      go(ADD, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0, lat, acc);
      drain("alias");
   endtask

   task automatic test_eql();
      int lat, acc;
      wr(4'd10, 256'h1234);
      wr(4'd11, 256'h1234);
      wr(4'd12, 256'd77);
      go(EQL, 4'd10, 4'd11, 4'd12, 1'b0, 1'b0, lat, acc);
      checks++;
      if (eql !== 1'b1 || lat !== 9) begin
         errors++;
         $display("FAIL eql_equal eql=%b lat=%0d exp 1 9", eql, lat);
      end
      sb_q.push_back(mk(4'd12, 256'd77));
      sb_q.push_back(mk(4'd13, 256'd8));
      go(ADD, 4'd3, 4'd4, 4'd13, 1'b0, 1'b0, lat, acc);
      checks++;
      if (eql !== 1'b1) begin errors++; $display("FAIL eql_hold got %b exp 1", eql); end
      wr(4'd11, (256'd1 << 254) | 256'h1234);
      go(EQL, 4'd10, 4'd11, 4'd12, 1'b0, 1'b0, lat, acc);
      checks++;
      if (eql !== 1'b0) begin errors++; $display("FAIL eql_top_bit got %b exp 0", eql); end
      drain("eql");
   endtask

   task automatic test_csw();
      int lat, acc;
      wr(4'd1, 256'd1);
      wr(4'd2, 256'd2);
      go(CSW, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0, lat, acc);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL csw1_latency got %0d exp 1", lat); end
      sb_q.push_back(mk(4'd1, 256'd2));
      sb_q.push_back(mk(4'd2, 256'd1));
      drain("csw1");
      go(CSW, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0, lat, acc);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL csw0_latency got %0d exp 1", lat); end
      sb_q.push_back(mk(4'd1, 256'd2));
      sb_q.push_back(mk(4'd2, 256'd1));
      go(CPY, 4'd2, 4'd0, 4'd14, 1'b0, 1'b0, lat, acc);
      sb_q.push_back(mk(4'd14, 256'd1));
      drain("csw0_cpy");
   endtask

   task automatic test_hold_val();
      int lat, acc, d0;
      wr(4'd15, 256'd0);
      wr(4'd4, 256'd7);
      d0 = done_cnt;
      go(ADD, 4'd15, 4'd4, 4'd15, 1'b0, 1'b1, lat, acc);
      repeat (12) @(posedge clk);
      #1;
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL hold_val_done_count got %0d exp 1", done_cnt - d0);
      end
      sb_q.push_back(mk(4'd15, 256'd7));
      drain("hold_val");
   endtask

   task automatic test_back_to_back();
      int lat, acc1, acc2, acc3, acc4;
      go(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, lat, acc1);
      go(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, lat, acc2);
      checks++;
      if (acc2 - acc1 !== 2 || lat !== 1) begin
         errors++;
         $display("FAIL b2b_nop gap=%0d lat=%0d exp 2 1", acc2 - acc1, lat);
      end
      go(ADD, 4'd3, 4'd4, 4'd13, 1'b0, 1'b0, lat, acc3);
      go(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, lat, acc4);
      checks++;
      if (acc4 - acc3 !== NL + 2) begin
         errors++;
         $display("FAIL b2b_add gap=%0d exp %0d", acc4 - acc3, NL + 2);
      end
      sb_q.push_back(mk(4'd13, 256'd12));
      drain("b2b");
   endtask

   task automatic test_small_field();
      logic [PW2-1:0] got;
      int n, d0;
      wr2(4'd0, P2W - 144'd1);
      wr2(4'd1, P2W - 144'd1);
      task_op2 = ADD; task_a2 = 4'd0; task_b2 = 4'd1; task_d2 = 4'd2; task_cnd2 = 1'b0;
      task_val2 = 1'b1;
      @(posedge clk); #1;
      task_val2 = 1'b0;
      n = 1;
      while (!task_done2 && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (n !== 10) begin errors++; $display("FAIL small_latency got %0d exp 10", n); end
      @(posedge clk); #1;
      rd2(4'd2, got);
      checks++;
      if (got !== P2W - 144'd2) begin
         errors++;
         $display("FAIL small_add got %h exp %h", got, P2W - 144'd2);
      end
      ext_rd_ptr2 = 4'd0;
      ext_rd_lmb2 = 4'd12;
      @(posedge clk); #1;
      checks++;
      if (ext_rd_dat2 !== 16'd0) begin
         errors++;
         $display("FAIL small_oob_limb got %h exp 0", ext_rd_dat2);
      end
      d0 = done2_cnt;
      task_val2 = 1'b1;
      @(posedge clk); #1;
      task_val2 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst2_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst2_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      checks++;
      if (done2_cnt !== d0 || task_rdy2 !== 1'b1 || eql2 !== 1'b0) begin
         errors++;
         $display("FAIL small_abort dones=%0d rdy=%b eql=%b exp 0 1 0",
                  done2_cnt - d0, task_rdy2, eql2);
      end
      for (int r = 0; r < 3; r++) begin
         rd2(4'(r), got);
         checks++;
         if (got !== '0) begin
            errors++;
            $display("FAIL small_reset_reg r%0d got %h exp 0", r, got);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      task_val = 1'b0; task_op = 3'd0; task_a = '0; task_b = '0; task_d = '0; task_cnd = 1'b0;
      ext_wr_val = 1'b0; ext_wr_ptr = '0; ext_wr_lmb = '0; ext_wr_dat = '0;
      ext_rd_ptr = '0; ext_rd_lmb = '0;
      task_val2 = 1'b0; task_op2 = 3'd0; task_a2 = '0; task_b2 = '0; task_d2 = '0; task_cnd2 = 1'b0;
      ext_wr_val2 = 1'b0; ext_wr_ptr2 = '0; ext_wr_lmb2 = '0; ext_wr_dat2 = '0;
      ext_rd_ptr2 = '0; ext_rd_lmb2 = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rst2_n = 1'b1;
      test_reset();
      test_add();
      test_sub();
      test_alias();
      test_eql();
      test_csw();
      test_hold_val();
      test_back_to_back();
      test_small_field();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
